// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU writeback stage.
//   - opcode encodings OP_ADD..OP_SRA (7 and 12-15 are illegal)
//   - bit positions of the {S,Z,C,V} flag register
//   - opcode classification helpers used by the stage
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SLR = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Count register width for the 2-entry writeback buffer (holds 0..2).
    localparam int CNT_W = 2;

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op == 4'd7) || (op > OP_SRA);
    endfunction

    // Every legal opcode except CMP produces a register writeback.
    function automatic logic op_writes_rd(input logic [3:0] op);
        return !is_illegal_op(op) && (op != OP_CMP);
    endfunction

    // Arithmetic ops and shifts report a carry/borrow or shifted-out bit.
    function automatic logic op_sets_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP) ||
               (op == OP_SLL) || (op == OP_SLR) || (op == OP_SRL) ||
               (op == OP_SRA);
    endfunction

    // Only the adder/subtractor ops can report signed overflow.
    function automatic logic op_sets_ovf(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_wb_stage_fifo.sv
// wb_fifo2: 2-entry writeback FIFO.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data (ignored when full)
//   pop         - retire the head entry (ignored when empty)
//   flush       - discard all entries; overrides push and pop
//   push_data   - entry to write
//   head_data   - oldest entry (zero after reset)
//   count       - number of valid entries (0..2)
module wb_fifo2
    import alu_pkg::*;
#(
    parameter int W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     push_data,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_reg != CNT_W'(2)) && !flush;
    assign do_pop  = pop  && (count_reg != CNT_W'(0)) && !flush;

    // Storage entries are reset so the head reads zero out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: registered stage after the ALU result mux.
// Captures each result with its destination register into a 2-entry
// writeback FIFO and maintains the {S,Z,C,V} flag register.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   in_valid / in_ready        - ALU result handshake (in_ready = count < 2)
//   opcode, result, carry_in, ovf_in, rd - ALU result and side information
//   flush                      - discard buffered writebacks
//   wb_valid / wb_ready        - register file handshake
//   wb_data, wb_rd             - head writeback entry
//   flags                      - {S,Z,C,V}
//   illegal                    - sticky illegal-opcode indicator
// Optional build macro ALU_WB_PERF_EN adds saturating counters:
//   perf_wb (pops), perf_stall (in_valid && !in_ready cycles),
//   perf_illegal (illegal accepts).
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] result,
    input  logic              carry_in,
    input  logic              ovf_in,
    input  logic [RD_W-1:0]   rd,
    input  logic              flush,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic [3:0]        flags,
    output logic              illegal
`ifdef ALU_WB_PERF_EN
    ,
    output logic [15:0]       perf_wb,
    output logic [15:0]       perf_stall,
    output logic [7:0]        perf_illegal
`endif
);

    localparam int ENTRY_W = DATA_W + RD_W;

    logic               accept;
    logic               op_illegal;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head_data;
    logic [3:0]         flags_reg;
    logic [3:0]         flags_next;
    logic               illegal_reg;
    logic               illegal_next;

    // in_ready depends only on the count register, so wb_ready never
    // reaches it combinationally; a full buffer refuses input even if
    // it is being popped in the same cycle.
    assign in_ready   = (count < CNT_W'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign op_illegal = is_illegal_op(opcode);
    assign push       = accept && op_writes_rd(opcode);
    assign pop        = wb_valid && wb_ready;

    wb_fifo2 #(
        .W(ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data ({result, rd}),
        .head_data (head_data),
        .count     (count)
    );

    assign wb_valid = (count != CNT_W'(0));
    assign wb_data  = head_data[ENTRY_W-1:RD_W];
    assign wb_rd    = head_data[RD_W-1:0];

    // Flags and the sticky illegal bit still update on an accept that
    // coincides with flush; only the push is dropped.
    always_comb begin
        flags_next   = flags_reg;
        illegal_next = illegal_reg;
        if (accept) begin
            if (op_illegal) begin
                illegal_next = 1'b1;
            end else begin
                flags_next[FLAG_S] = result[DATA_W-1];
                flags_next[FLAG_Z] = (result == '0);
                flags_next[FLAG_C] = op_sets_carry(opcode) ? carry_in : 1'b0;
                flags_next[FLAG_V] = op_sets_ovf(opcode)   ? ovf_in   : 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg   <= 4'b0000;
            illegal_reg <= 1'b0;
        end else begin
            flags_reg   <= flags_next;
            illegal_reg <= illegal_next;
        end
    end

    assign flags   = flags_reg;
    assign illegal = illegal_reg;

`ifdef ALU_WB_PERF_EN
    logic [15:0] perf_wb_reg;
    logic [15:0] perf_stall_reg;
    logic [7:0]  perf_illegal_reg;

    // Saturating event counters; flush has no effect on them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_wb_reg      <= '0;
            perf_stall_reg   <= '0;
            perf_illegal_reg <= '0;
        end else begin
            if (pop && (perf_wb_reg != '1))
                perf_wb_reg <= perf_wb_reg + 16'd1;
            if (in_valid && !in_ready && (perf_stall_reg != '1))
                perf_stall_reg <= perf_stall_reg + 16'd1;
            if (accept && op_illegal && (perf_illegal_reg != '1))
                perf_illegal_reg <= perf_illegal_reg + 8'd1;
        end
    end

    assign perf_wb      = perf_wb_reg;
    assign perf_stall   = perf_stall_reg;
    assign perf_illegal = perf_illegal_reg;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: self-checking bench for alu_wb_stage.
// Writebacks are predicted into a scoreboard queue when the stimulus is
// accepted and compared in order as the DUT pops them; flags and status
// are checked against a small local flag model.
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = 4'd0;
    logic [15:0] result = 16'd0;
    logic        carry_in = 1'b0;
    logic        ovf_in = 1'b0;
    logic [2:0]  rd = 3'd0;
    logic        flush = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic [3:0]  flags;
    logic        illegal;
`ifdef ALU_WB_PERF_EN
    logic [15:0] perf_wb;
    logic [15:0] perf_stall;
    logic [7:0]  perf_illegal;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int pops = 0;
    logic [18:0] sb[$];
    logic [3:0]  exp_flags = 4'b0000;

    always #5 clk = ~clk;

    alu_wb_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .result   (result),
        .carry_in (carry_in),
        .ovf_in   (ovf_in),
        .rd       (rd),
        .flush    (flush),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_rd    (wb_rd),
        .flags    (flags),
        .illegal  (illegal)
`ifdef ALU_WB_PERF_EN
        ,
        .perf_wb      (perf_wb),
        .perf_stall   (perf_stall),
        .perf_illegal (perf_illegal)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic tb_writes(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference flag model: {S,Z,C,V}; illegal opcodes leave flags alone.
    function automatic logic [3:0] model_flags(input logic [3:0] op, input logic [15:0] res,
                                               input logic c, input logic v, input logic [3:0] old);
        logic s, z;
        s = res[15];
        z = (res == 16'h0000);
        case (op)
            4'd0, 4'd1, 4'd5:                 return {s, z, c, v};
            4'd8, 4'd9, 4'd10, 4'd11:         return {s, z, c, 1'b0};
            4'd2, 4'd3, 4'd4, 4'd6:           return {s, z, 2'b00};
            default:                          return old;
        endcase
    endfunction

    // Drive one ALU result; called at posedge+1, returns at posedge+1 after accept.
    task automatic send(input logic [3:0] op, input logic [15:0] res, input logic c,
                        input logic v, input logic [2:0] r);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        opcode   = op;
        result   = res;
        carry_in = c;
        ovf_in   = v;
        rd       = r;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            if (tb_writes(op)) sb.push_back({res, r});
            exp_flags = model_flags(op, res, c, v, exp_flags);
            $display("[TB] send op=%0d result=0x%04h rd=%0d", op, res, r);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Writeback monitor: every pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                check("wb_unexpected_pop", {13'd0, wb_rd, wb_data}, 32'd0);
            end else begin
                logic [18:0] e;
                e = sb.pop_front();
                check("wb_data", {16'd0, wb_data}, {16'd0, e[18:3]});
                check("wb_rd", {29'd0, wb_rd}, {29'd0, e[2:0]});
                pops++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", {16'd0, wb_data}, 32'd0);
        check("rst_wb_rd", {29'd0, wb_rd}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD into empty FIFO: visible next cycle
        wb_ready = 1'b1;
        send(4'd0, 16'h8000, 1'b0, 1'b1, 3'd3);
        check("add_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("add_wb_data", {16'd0, wb_data}, 32'h8000);
        check("add_wb_rd", {29'd0, wb_rd}, 32'd3);
        check("add_flags", {28'd0, flags}, {28'd0, exp_flags});
        check("add_flags_lit", {28'd0, flags}, 32'b1001);

        // CMP: flags only
        send(4'd5, 16'h0000, 1'b1, 1'b0, 3'd1);
        check("cmp_flags", {28'd0, flags}, 32'b0110);
        check("cmp_wb_valid", {31'd0, wb_valid}, 32'd0);

        // Illegal opcode: sticky, flags unchanged, no writeback
        send(4'd7, 16'hFFFF, 1'b1, 1'b1, 3'd2);
        check("ill_illegal", {31'd0, illegal}, 32'd1);
        check("ill_flags", {28'd0, flags}, {28'd0, exp_flags});
        check("ill_wb_valid", {31'd0, wb_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("ill_sticky", {31'd0, illegal}, 32'd1);

        // Back-to-back ANDs with the register file stalled
        wb_ready = 1'b0;
        send(4'd2, 16'h0001, 1'b1, 1'b1, 3'd1);
        send(4'd2, 16'h0002, 1'b1, 1'b1, 3'd2);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        fork
            send(4'd2, 16'h0003, 1'b1, 1'b1, 3'd3);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                check("stall_head_stable", {16'd0, wb_data}, 32'h0001);
                check("stall_rd_stable", {29'd0, wb_rd}, 32'd1);
                wb_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("and_drained", {31'd0, wb_valid}, 32'd0);
        check("and_flags", {28'd0, flags}, {28'd0, exp_flags});

        // Flush with a simultaneous SUB accept: flags update, push dropped
        wb_ready = 1'b0;
        send(4'd2, 16'h1234, 1'b0, 1'b0, 3'd1);
        check("pre_flush_flags", {28'd0, flags}, 32'b0000);
        flush    = 1'b1;
        in_valid = 1'b1;
        opcode   = 4'd1;
        result   = 16'h0000;
        carry_in = 1'b1;
        ovf_in   = 1'b0;
        rd       = 3'd5;
        @(negedge clk);
        check("flush_sub_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        exp_flags = model_flags(4'd1, 16'h0000, 1'b1, 1'b0, exp_flags);
        check("flush_sub_flags", {28'd0, flags}, 32'b0110);
        check("flush_sub_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("flush_sub_in_ready2", {31'd0, in_ready}, 32'd1);

        // Flush of a full buffer
        send(4'd3, 16'h00AA, 1'b0, 1'b0, 3'd2);
        send(4'd4, 16'h00BB, 1'b0, 1'b0, 3'd4);
        check("flush_full_in_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        sb.delete();
        check("flush_full_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("flush_full_in_ready2", {31'd0, in_ready}, 32'd1);

        // After flush only new entries appear; back-to-back pushes with pops
        wb_ready = 1'b1;
        send(4'd6, 16'h0042, 1'b0, 1'b0, 3'd6);
        send(4'd8, 16'h0084, 1'b1, 1'b0, 3'd7);
        send(4'd11, 16'hC000, 1'b0, 1'b1, 3'd0);
        check("shift_flags", {28'd0, flags}, {28'd0, exp_flags});
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset while an entry is waiting
        wb_ready = 1'b0;
        send(4'd2, 16'h8000, 1'b0, 1'b0, 3'd7);
        check("prerst_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("prerst_flags", {28'd0, flags}, 32'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_flags = 4'b0000;
        check("async_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("async_rst_flags", {28'd0, flags}, 32'd0);
        check("async_rst_illegal", {31'd0, illegal}, 32'd0);
        check("async_rst_wb_data", {16'd0, wb_data}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD + 3 ANDs + MOV + SLL + SRA
        check("pop_total", pops, 32'd7);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
